// File: rtl/step_control_decoder.sv
// Step control decoder for the multi-cycle datapath: turns the clock-counter step,
// opcode and ALU Zero flag into registered per-step strobes, and traps faults and HALT.
module step_control_decoder #(
    parameter int STEPS = 5,
    parameter int OPW   = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [2:0]     ClockCount,
    input  logic [OPW-1:0] Opcode,
    input  logic           Zero,
    output logic           PCEnable,
    output logic           PCSelect,
    output logic           IREnable,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           RFWrite,
    output logic [2:0]     ALUOp,
    output logic           BSelect,
    output logic           YSelect,
    output logic           Halted,
    output logic           Fault,
    output logic [1:0]     FaultCode
);

    typedef enum logic [1:0] {SYNC, RUN, HALTED, FAULT} state_t;

    localparam logic [2:0]     LAST    = 3'(STEPS);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4);
    localparam logic [OPW-1:0] OP_LD   = OPW'(5);
    localparam logic [OPW-1:0] OP_ST   = OPW'(6);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(7);
    localparam logic [OPW-1:0] OP_BR   = OPW'(8);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(9);
    localparam logic [OPW-1:0] OP_HALT = OPW'(10);

    state_t         r_state;
    logic [2:0]     r_exp_step;
    logic [OPW-1:0] r_op_reg;

    logic       w_out_of_range;
    logic [2:0] w_next_step;

    assign w_out_of_range = (ClockCount == 3'd0) || (ClockCount > LAST);
    assign w_next_step    = (ClockCount == LAST) ? 3'd1 : ClockCount + 3'd1;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= SYNC;
            r_exp_step <= 3'd1;
            r_op_reg   <= '0;
            PCEnable   <= 1'b0;
            PCSelect   <= 1'b0;
            IREnable   <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            RFWrite    <= 1'b0;
            ALUOp      <= 3'b000;
            BSelect    <= 1'b0;
            YSelect    <= 1'b0;
            Halted     <= 1'b0;
            Fault      <= 1'b0;
            FaultCode  <= 2'b00;
        end else begin
            // NOTE: strobes default to 0 each edge and are overridden below; non-blocking
            // assignment makes the last write win without creating ordering hazards.
            PCEnable <= 1'b0;
            PCSelect <= 1'b0;
            IREnable <= 1'b0;
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            RFWrite  <= 1'b0;
            ALUOp    <= 3'b000;
            BSelect  <= 1'b0;
            YSelect  <= 1'b0;

            case (r_state)
                SYNC: begin
                    if (ClockCount == 3'd1) begin
                        r_state    <= RUN;
                        r_exp_step <= 3'd2;
                        MemRead    <= 1'b1;
                        IREnable   <= 1'b1;
                        PCEnable   <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_out_of_range) begin
                        r_state   <= FAULT;
                        Fault     <= 1'b1;
                        FaultCode <= 2'b11;
                    end else if (ClockCount != r_exp_step) begin
                        r_state   <= FAULT;
                        Fault     <= 1'b1;
                        FaultCode <= 2'b10;
                    end else begin
                        r_exp_step <= w_next_step;
                        case (ClockCount)
                            3'd1: begin
                                MemRead  <= 1'b1;
                                IREnable <= 1'b1;
                                PCEnable <= 1'b1;
                            end
                            3'd2: begin
                                r_op_reg <= Opcode;
                                if (Opcode > OP_HALT) begin
                                    r_state   <= FAULT;
                                    Fault     <= 1'b1;
                                    FaultCode <= 2'b01;
                                end else if (Opcode == OP_HALT) begin
                                    r_state <= HALTED;
                                    Halted  <= 1'b1;
                                end
                            end
                            3'd3: begin
                                case (r_op_reg)
                                    OP_ADD: ALUOp <= 3'b001;
                                    OP_SUB: ALUOp <= 3'b010;
                                    OP_AND: ALUOp <= 3'b011;
                                    OP_OR:  ALUOp <= 3'b100;
                                    OP_ADDI, OP_LD, OP_ST: begin
                                        ALUOp   <= 3'b001;
                                        BSelect <= 1'b1;
                                    end
                                    OP_BR: begin
                                        PCEnable <= 1'b1;
                                        PCSelect <= 1'b1;
                                    end
                                    OP_BEQ: begin
                                        PCEnable <= Zero;
                                        PCSelect <= Zero;
                                    end
                                    default: ;
                                endcase
                            end
                            3'd4: begin
                                MemRead  <= (r_op_reg == OP_LD);
                                MemWrite <= (r_op_reg == OP_ST);
                            end
                            3'd5: begin
                                RFWrite <= (r_op_reg == OP_ADD) || (r_op_reg == OP_SUB) ||
                                           (r_op_reg == OP_AND) || (r_op_reg == OP_OR)  ||
                                           (r_op_reg == OP_ADDI) || (r_op_reg == OP_LD);
                                YSelect <= (r_op_reg == OP_LD);
                            end
                            default: ;
                        endcase
                    end
                end
                // Trap states hold Halted/Fault/FaultCode until Reset; only strobes clear.
                HALTED: ;
                FAULT:  ;
                default: r_state <= SYNC;
            endcase
        end
    end

    // OP_NOP is the implicit "no action" case in every step decode.
    logic w_unused_nop;
    assign w_unused_nop = (r_op_reg == OP_NOP);

endmodule

// File: tb/tb_step_control_decoder.sv
// Table-driven, scoreboard-checked bench for step_control_decoder.
module tb_step_control_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cc  = 3'd0;
    logic [3:0] op  = 4'd0;
    logic       z   = 1'b0;

    logic       pce, pcs, ire, mr, mw, rfw, bs, ys, halted, fault;
    logic [2:0] alu;
    logic [1:0] fcode;

    step_control_decoder #(.STEPS(5), .OPW(4)) dut (
        .Clock(clk), .Reset(rst), .ClockCount(cc), .Opcode(op), .Zero(z),
        .PCEnable(pce), .PCSelect(pcs), .IREnable(ire), .MemRead(mr), .MemWrite(mw),
        .RFWrite(rfw), .ALUOp(alu), .BSelect(bs), .YSelect(ys),
        .Halted(halted), .Fault(fault), .FaultCode(fcode)
    );

    always #5 clk = ~clk;

    // {PCEnable,PCSelect,IREnable,MemRead,MemWrite,RFWrite,ALUOp,BSelect,YSelect,Halted,Fault,FaultCode}
    logic [14:0] act;
    assign act = {pce, pcs, ire, mr, mw, rfw, alu, bs, ys, halted, fault, fcode};

    typedef struct {
        logic [2:0]  cc;
        logic [3:0]  op;
        logic        z;
        logic [14:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [14:0] sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [14:0] mk(input logic pce_e, pcs_e, ire_e, mr_e, mw_e, rfw_e,
                                       input logic [2:0] alu_e, input logic bs_e, ys_e,
                                       input logic h_e, f_e, input logic [1:0] fc_e);
        return {pce_e, pcs_e, ire_e, mr_e, mw_e, rfw_e, alu_e, bs_e, ys_e, h_e, f_e, fc_e};
    endfunction

    logic [14:0] NONE, FETCH, ALU1, ALU2, ALU3, ALU4, ALU1B, BRT, MRD, MWR, WB_ALU, WB_MEM;
    logic [14:0] HLT, FLT01, FLT10, FLT11;

    task automatic check(input string name, input logic [14:0] a, input logic [14:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, a, e);
        end
    endtask

    task automatic add(input logic [2:0] c, input logic [3:0] o, input logic zz,
                       input logic [14:0] e);
        vec_t v;
        v.cc = c; v.op = o; v.z = zz; v.exp = e;
        vecs.push_back(v);
    endtask

    // One instruction from decode through the next fetch; junk opcode off step 2.
    task automatic add_instr(input logic [3:0] o, input logic zz,
                             input logic [14:0] e3, input logic [14:0] e4, input logic [14:0] e5);
        add(3'd2, o, 1'b0, NONE);
        add(3'd3, 4'hF, zz, e3);
        add(3'd4, 4'hF, 1'b0, e4);
        add(3'd5, 4'hF, 1'b0, e5);
        add(3'd1, 4'hF, 1'b0, FETCH);
    endtask

    task automatic drive(input logic [2:0] c, input logic [3:0] o, input logic zz,
                         input logic [14:0] e, input string name);
        @(negedge clk);
        cc = c; op = o; z = zz;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check(name, act, sb_q.pop_front());
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check(name, act, NONE);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        NONE   = '0;
        FETCH  = mk(1,0,1,1,0,0,3'b000,0,0,0,0,2'b00);
        ALU1   = mk(0,0,0,0,0,0,3'b001,0,0,0,0,2'b00);
        ALU2   = mk(0,0,0,0,0,0,3'b010,0,0,0,0,2'b00);
        ALU3   = mk(0,0,0,0,0,0,3'b011,0,0,0,0,2'b00);
        ALU4   = mk(0,0,0,0,0,0,3'b100,0,0,0,0,2'b00);
        ALU1B  = mk(0,0,0,0,0,0,3'b001,1,0,0,0,2'b00);
        BRT    = mk(1,1,0,0,0,0,3'b000,0,0,0,0,2'b00);
        MRD    = mk(0,0,0,1,0,0,3'b000,0,0,0,0,2'b00);
        MWR    = mk(0,0,0,0,1,0,3'b000,0,0,0,0,2'b00);
        WB_ALU = mk(0,0,0,0,0,1,3'b000,0,0,0,0,2'b00);
        WB_MEM = mk(0,0,0,0,0,1,3'b000,0,1,0,0,2'b00);
        HLT    = mk(0,0,0,0,0,0,3'b000,0,0,1,0,2'b00);
        FLT01  = mk(0,0,0,0,0,0,3'b000,0,0,0,1,2'b01);
        FLT10  = mk(0,0,0,0,0,0,3'b000,0,0,0,1,2'b10);
        FLT11  = mk(0,0,0,0,0,0,3'b000,0,0,0,1,2'b11);

        // SYNC ignores 3,4,5 (with a legal opcode at 2 later), realigns on 1.
        add(3'd3, 4'd1, 1'b0, NONE);
        add(3'd4, 4'd1, 1'b0, NONE);
        add(3'd5, 4'd1, 1'b0, NONE);
        add(3'd1, 4'd1, 1'b0, FETCH);
        add_instr(4'd1, 1'b1, ALU1,  NONE, WB_ALU);  // ADD, Zero has no effect
        add_instr(4'd5, 1'b0, ALU1B, MRD,  WB_MEM);  // LD
        add_instr(4'd6, 1'b0, ALU1B, MWR,  NONE);    // ST
        add_instr(4'd9, 1'b1, BRT,   NONE, NONE);    // BEQ taken
        add_instr(4'd9, 1'b0, NONE,  NONE, NONE);    // BEQ not taken
        add_instr(4'd8, 1'b0, BRT,   NONE, NONE);    // BR ignores Zero
        add_instr(4'd2, 1'b0, ALU2,  NONE, WB_ALU);  // SUB
        add_instr(4'd3, 1'b0, ALU3,  NONE, WB_ALU);  // AND
        add_instr(4'd4, 1'b0, ALU4,  NONE, WB_ALU);  // OR
        add_instr(4'd7, 1'b0, ALU1B, NONE, WB_ALU);  // ADDI
        add_instr(4'd0, 1'b1, NONE,  NONE, NONE);    // NOP
        add(3'd2, 4'd12, 1'b0, FLT01);               // illegal opcode
        for (int i = 0; i < 10; i++)
            add(3'((i % 5) + 3 > 5 ? (i % 5) - 2 : (i % 5) + 3), 4'd1, 1'b1, FLT01);

        do_reset("reset_state");
        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i].cc, vecs[i].op, vecs[i].z, vecs[i].exp, $sformatf("vec%0d", i));

        // Reset clears the fault; SYNC ignores step 2, then a skipped step traps code 10.
        do_reset("reset_clears_fault");
        drive(3'd2, 4'd1, 1'b0, NONE,  "sync_ignores_2");
        drive(3'd1, 4'd1, 1'b0, FETCH, "seq_fetch");
        drive(3'd2, 4'd1, 1'b0, NONE,  "seq_decode");
        drive(3'd4, 4'd1, 1'b0, FLT10, "seq_error");
        drive(3'd3, 4'd1, 1'b0, FLT10, "seq_error_frozen");

        do_reset("reset_before_range");
        drive(3'd1, 4'd1, 1'b0, FETCH, "range_fetch");
        drive(3'd6, 4'd1, 1'b0, FLT11, "range_error");
        drive(3'd2, 4'd1, 1'b0, FLT11, "range_error_frozen");

        do_reset("reset_before_halt");
        drive(3'd1, 4'd10, 1'b0, FETCH, "halt_fetch");
        drive(3'd2, 4'd10, 1'b0, HLT,   "halt_decode");
        for (int i = 0; i < 10; i++)
            drive(3'(((i + 2) % 5) + 1), 4'd1, 1'b1, HLT, $sformatf("halt_hold%0d", i));

        do_reset("reset_before_async");
        drive(3'd1, 4'd1, 1'b0, FETCH, "async_fetch");
        drive(3'd2, 4'd1, 1'b0, NONE,  "async_decode");
        drive(3'd3, 4'd1, 1'b0, ALU1,  "async_execute");
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_clear", act, NONE);
        @(negedge clk);
        rst = 1'b0;
        drive(3'd4, 4'd1, 1'b0, NONE,  "async_resync_wait");
        drive(3'd1, 4'd1, 1'b0, FETCH, "async_resync_fetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
